warp_fetch_scheduler: RTL and testbench

//  Shares the single 64-bit instruction-memory port among NUM_WARPS warps. Holds one PC and a state per warp, round-robin

---
 rtl/gpu_fetch_pkg.sv | 26 ++
 rtl/warp_fetch_scheduler_if.sv | 47 ++++
 rtl/warp_fetch_scheduler_rr_arbiter.sv | 40 ++++
 rtl/warp_fetch_scheduler.sv | 155 +++++++++++++++
 tb/tb_warp_fetch_scheduler.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_fetch_pkg.sv
// rtl/gpu_fetch_pkg.sv - shared types and helpers for the warp fetch scheduler
package gpu_fetch_pkg;

  localparam int BUNDLE_BYTES = 8;
  localparam int WID_MAX_W    = 8;

  typedef enum logic [1:0] {W_IDLE, W_READY, W_FETCH, W_WAIT_ADV} warp_state_e;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_RESP, F_OUT} fetch_state_e;

  typedef struct packed {
    logic [WID_MAX_W-1:0] warp;
    logic [31:0]          pc;
    logic [63:0]          data;
  } fetch_bundle_t;

  function automatic logic [31:0] align_addr(input logic [31:0] pc);
    return {pc[31:3], 3'b000};
  endfunction

  // A PC in the upper half of a bundle only has 4 bytes left to consume.
  function automatic logic [3:0] adv_step(input logic [31:0] pc, input logic [3:0] bytes);
    if (pc[2] && bytes == 4'(BUNDLE_BYTES)) return 4'd4;
    return bytes;
  endfunction

endpackage

// File: rtl/warp_fetch_scheduler_if.sv
// rtl/warp_fetch_scheduler_if.sv - control, instruction-memory and decode signals of the fetch scheduler
interface warp_fetch_scheduler_if #(parameter int NUM_WARPS = 4);
  localparam int WID_W = $clog2(NUM_WARPS);

  logic                 start_valid;
  logic [WID_W-1:0]     start_warp;
  logic [31:0]          start_pc;
  logic                 halt_valid;
  logic [WID_W-1:0]     halt_warp;
  logic                 redir_valid;
  logic [WID_W-1:0]     redir_warp;
  logic [31:0]          redir_pc;
  logic                 adv_valid;
  logic [WID_W-1:0]     adv_warp;
  logic [3:0]           adv_bytes;
  logic                 imem_req_valid;
  logic [31:0]          imem_req_addr;
  logic                 imem_req_ready;
  logic                 imem_rsp_valid;
  logic [63:0]          imem_rsp_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WID_W-1:0]     out_warp;
  logic [31:0]          out_pc;
  logic [31:0]          out_inst0;
  logic [31:0]          out_inst1;
  logic                 out_inst0_valid;
  logic                 out_inst1_valid;
  logic [NUM_WARPS-1:0] busy_warps;

  modport master (
    input  start_valid, start_warp, start_pc, halt_valid, halt_warp,
           redir_valid, redir_warp, redir_pc, adv_valid, adv_warp, adv_bytes,
           imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_warp, out_pc,
           out_inst0, out_inst1, out_inst0_valid, out_inst1_valid, busy_warps
  );

  modport slave (
    output start_valid, start_warp, start_pc, halt_valid, halt_warp,
           redir_valid, redir_warp, redir_pc, adv_valid, adv_warp, adv_bytes,
           imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_warp, out_pc,
           out_inst0, out_inst1, out_inst0_valid, out_inst1_valid, busy_warps
  );

endinterface

// File: rtl/warp_fetch_scheduler_rr_arbiter.sv
// rtl/warp_fetch_scheduler_rr_arbiter.sv - round-robin arbiter starting after the last granted requester
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  logic [W-1:0] ptr;
  logic [W-1:0] idx;

  // Scan requesters from the pointer upward, wrapping; first hit wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

  // Move the pointer past the winner so it has lowest priority next time.
  always_ff @(posedge clk) begin
    if (!rst_n)         ptr <= '0;
    else if (gnt_valid) ptr <= gnt_idx + W'(1);
  end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// rtl/warp_fetch_scheduler.sv - shares one 64-bit instruction-memory port among warps, one fetch in flight
module warp_fetch_scheduler
  import gpu_fetch_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WID_W     = $clog2(NUM_WARPS)
) (
  input logic                      clk,
  input logic                      rst_n,
  warp_fetch_scheduler_if.master   bus
);

  warp_state_e          wstate [NUM_WARPS];
  logic [31:0]          wpc    [NUM_WARPS];
  fetch_state_e         fstate, fstate_next;
  logic                 kill, kill_next;
  fetch_bundle_t        cur;
  logic [WID_W-1:0]     cur_warp;
  logic [NUM_WARPS-1:0] ready_vec;
  logic [NUM_WARPS-1:0] gnt;
  logic [WID_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic                 hit;
  logic                 accept;
  logic                 granting;
  logic                 unused_warp_bits;

  assign cur_warp         = cur.warp[WID_W-1:0];
  assign unused_warp_bits = ^cur.warp;

  // A halt or redirect aimed at the warp owning the in-flight fetch kills it.
  assign hit = (fstate != F_IDLE) &&
               ((bus.halt_valid  && bus.halt_warp  == cur_warp) ||
                (bus.redir_valid && bus.redir_warp == cur_warp));
  assign accept   = (fstate == F_OUT) && bus.out_ready && !hit;
  assign granting = (fstate == F_IDLE) && gnt_valid;

  // Warps being halted or redirected this cycle sit out arbitration so a grant never uses a stale PC.
  always_comb begin
    ready_vec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      ready_vec[w] = (wstate[w] == W_READY) &&
                     !(bus.halt_valid  && bus.halt_warp  == WID_W'(w)) &&
                     !(bus.redir_valid && bus.redir_warp == WID_W'(w));
    end
  end

  rr_arbiter #(.N(NUM_WARPS), .W(WID_W)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (ready_vec),
    .en        (fstate == F_IDLE),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Fetch FSM state and kill flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fstate <= F_IDLE;
      kill   <= 1'b0;
    end else begin
      fstate <= fstate_next;
      kill   <= kill_next;
    end
  end

  // Fetch FSM next state; a request is never retracted, a killed response is swallowed.
  always_comb begin
    fstate_next = fstate;
    kill_next   = kill;
    case (fstate)
      F_IDLE: begin
        kill_next = 1'b0;
        if (gnt_valid) fstate_next = F_REQ;
      end
      F_REQ: begin
        if (hit) kill_next = 1'b1;
        if (bus.imem_req_ready) fstate_next = F_RESP;
      end
      F_RESP: begin
        if (hit) kill_next = 1'b1;
        if (bus.imem_rsp_valid) begin
          fstate_next = (kill || hit) ? F_IDLE : F_OUT;
          kill_next   = 1'b0;
        end
      end
      F_OUT: begin
        if (hit || bus.out_ready) fstate_next = F_IDLE;
      end
      default: fstate_next = F_IDLE;
    endcase
  end

  // Capture owner/PC at grant and data on a live response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= '0;
    end else begin
      if (granting) begin
        cur.warp <= WID_MAX_W'(gnt_idx);
        cur.pc   <= wpc[gnt_idx];
      end
      if (fstate == F_RESP && bus.imem_rsp_valid && !(kill || hit))
        cur.data <= bus.imem_rsp_data;
    end
  end

  // Per-warp state and PC; halt > redir > adv > start for the same warp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        wstate[w] <= W_IDLE;
        wpc[w]    <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (bus.halt_valid && bus.halt_warp == WID_W'(w)) begin
          wstate[w] <= W_IDLE;
        end else if (bus.redir_valid && bus.redir_warp == WID_W'(w) && wstate[w] != W_IDLE) begin
          wstate[w] <= W_READY;
          wpc[w]    <= bus.redir_pc;
        end else if (bus.adv_valid && bus.adv_warp == WID_W'(w) && wstate[w] == W_WAIT_ADV) begin
          wstate[w] <= W_READY;
          wpc[w]    <= wpc[w] + 32'(adv_step(wpc[w], bus.adv_bytes));
        end else if (bus.start_valid && bus.start_warp == WID_W'(w) && wstate[w] == W_IDLE) begin
          wstate[w] <= W_READY;
          wpc[w]    <= bus.start_pc;
        end else if (granting && gnt[w]) begin
          wstate[w] <= W_FETCH;
        end else if (accept && cur_warp == WID_W'(w)) begin
          wstate[w] <= W_WAIT_ADV;
        end
      end
    end
  end

  // Busy vector mirrors which warps are launched.
  always_comb begin
    bus.busy_warps = '0;
    for (int w = 0; w < NUM_WARPS; w++) bus.busy_warps[w] = (wstate[w] != W_IDLE);
  end

  assign bus.imem_req_valid  = (fstate == F_REQ);
  assign bus.imem_req_addr   = align_addr(cur.pc);
  assign bus.out_valid       = (fstate == F_OUT);
  assign bus.out_warp        = cur_warp;
  assign bus.out_pc          = cur.pc;
  assign bus.out_inst0       = cur.pc[2] ? cur.data[63:32] : cur.data[31:0];
  assign bus.out_inst1       = cur.data[63:32];
  assign bus.out_inst0_valid = (fstate == F_OUT);
  assign bus.out_inst1_valid = (fstate == F_OUT) && !cur.pc[2];

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// tb/tb_warp_fetch_scheduler.sv - directed vector bench for the warp fetch scheduler
module tb_warp_fetch_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  warp_fetch_scheduler_if #(.NUM_WARPS(4)) bus ();

  warp_fetch_scheduler #(.NUM_WARPS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst, sv, hv, rv, av, rdy, rsp, ordy;
    logic [1:0]  sw, hw, rw, aw;
    logic [31:0] spc, rpc, ra;
    logic [3:0]  ab;
    logic        ereq, eout, ei1v;
    logic [31:0] eaddr, epc;
    logic [1:0]  ew;
    logic [3:0]  eb;
  } vec_t;

  vec_t r;
  vec_t v;
  vec_t vq[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 + a;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic push();
    vq.push_back(r);
    r.rst = 0; r.sv = 0; r.hv = 0; r.rv = 0; r.av = 0; r.rsp = 0;
  endtask

  task automatic idle_inputs();
    bus.start_valid = 0; bus.start_warp = 0; bus.start_pc = 0;
    bus.halt_valid = 0; bus.halt_warp = 0;
    bus.redir_valid = 0; bus.redir_warp = 0; bus.redir_pc = 0;
    bus.adv_valid = 0; bus.adv_warp = 0; bus.adv_bytes = 0;
    bus.imem_req_ready = 1; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
    bus.out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a request, answers it one cycle after acceptance and checks the presented bundle.
  task automatic fetch_one(input logic [31:0] eaddr, input logic [31:0] epc,
                           input logic [1:0] ew, input logic ei1v);
    int n;
    n = 0;
    while (!bus.imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk("hs_req_valid", n, 32'(bus.imem_req_valid), 32'd1);
    chk("hs_req_addr", n, bus.imem_req_addr, eaddr);
    tick();
    bus.imem_rsp_valid = 1;
    bus.imem_rsp_data  = {word(eaddr + 32'd4), word(eaddr)};
    tick();
    bus.imem_rsp_valid = 0;
    chk("hs_out_valid", 0, 32'(bus.out_valid), 32'd1);
    chk("hs_out_pc", 0, bus.out_pc, epc);
    chk("hs_out_warp", 0, 32'(bus.out_warp), 32'(ew));
    chk("hs_inst0", 0, bus.out_inst0, word(epc));
    chk("hs_inst1", 0, bus.out_inst1, word(eaddr + 32'd4));
    chk("hs_inst1_valid", 0, 32'(bus.out_inst1_valid), 32'(ei1v));
    tick();
  endtask

  initial begin
    idle_inputs();

    // Reset with a stray response on the bus: everything must read zero.
    rst_n = 0;
    bus.imem_rsp_valid = 1;
    bus.imem_rsp_data  = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (3) tick();
    chk("rst_req_valid", 0, 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr", 0, bus.imem_req_addr, 32'd0);
    chk("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", 0, bus.out_pc, 32'd0);
    chk("rst_inst0", 0, bus.out_inst0, 32'd0);
    chk("rst_inst1", 0, bus.out_inst1, 32'd0);
    chk("rst_inst1_valid", 0, 32'(bus.out_inst1_valid), 32'd0);
    chk("rst_busy", 0, 32'(bus.busy_warps), 32'd0);
    bus.imem_rsp_valid = 0;

    r = '{default: '0};
    r.rdy = 1; r.ordy = 1; r.ab = 4'd8;

    // w0 @0x100, full bundle, adv 8, then halted while its request is in flight.
    r.sv = 1; r.sw = 0; r.spc = 32'h100; r.eb = 4'h1; push();
    r.ereq = 1; r.eaddr = 32'h100; push();
    r.ereq = 0; push();
    r.rsp = 1; r.ra = 32'h100; r.eout = 1; r.ew = 0; r.epc = 32'h100; r.ei1v = 1; push();
    r.eout = 0; push();
    r.av = 1; r.aw = 0; r.ab = 4'd8; push();
    r.ereq = 1; r.eaddr = 32'h108; push();
    r.hv = 1; r.hw = 0; r.ereq = 0; r.eb = 4'h0; push();
    r.rsp = 1; r.ra = 32'h108; push();
    push();
    // w1 @0x204: upper-half start, adv 8 clamped to 4.
    r.sv = 1; r.sw = 1; r.spc = 32'h204; r.eb = 4'h2; push();
    r.ereq = 1; r.eaddr = 32'h200; push();
    r.ereq = 0; push();
    r.rsp = 1; r.ra = 32'h200; r.eout = 1; r.ew = 1; r.epc = 32'h204; r.ei1v = 0; push();
    r.eout = 0; push();
    r.av = 1; r.aw = 1; r.ab = 4'd8; push();
    r.ereq = 1; r.eaddr = 32'h208; push();
    r.ereq = 0; push();
    r.rsp = 1; r.ra = 32'h208; r.eout = 1; r.ew = 1; r.epc = 32'h208; r.ei1v = 1; push();
    r.eout = 0; push();
    r.hv = 1; r.hw = 1; r.eb = 4'h0; push();
    r.rst = 1; r.rsp = 1; r.ra = 32'h0; push();
    // Four warps ready: grants w0,w1,w2,w3,w0.
    r.sv = 1; r.sw = 0; r.spc = 32'h1000; r.eb = 4'h1; push();
    r.sv = 1; r.sw = 1; r.spc = 32'h2000; r.eb = 4'h3; r.ereq = 1; r.eaddr = 32'h1000; push();
    r.sv = 1; r.sw = 2; r.spc = 32'h3000; r.eb = 4'h7; r.ereq = 0; push();
    r.sv = 1; r.sw = 3; r.spc = 32'h4000; r.eb = 4'hF;
    r.rsp = 1; r.ra = 32'h1000; r.eout = 1; r.ew = 0; r.epc = 32'h1000; r.ei1v = 1; push();
    r.eout = 0; push();
    r.av = 1; r.aw = 0; r.ereq = 1; r.eaddr = 32'h2000; push();
    r.ereq = 0; push();
    r.rsp = 1; r.ra = 32'h2000; r.eout = 1; r.ew = 1; r.epc = 32'h2000; push();
    r.eout = 0; push();
    r.av = 1; r.aw = 1; r.ereq = 1; r.eaddr = 32'h3000; push();
    r.ereq = 0; push();
    r.rsp = 1; r.ra = 32'h3000; r.eout = 1; r.ew = 2; r.epc = 32'h3000; push();
    r.eout = 0; push();
    r.av = 1; r.aw = 2; r.ereq = 1; r.eaddr = 32'h4000; push();
    r.ereq = 0; push();
    r.rsp = 1; r.ra = 32'h4000; r.eout = 1; r.ew = 3; r.epc = 32'h4000; push();
    r.eout = 0; push();
    r.av = 1; r.aw = 3; r.ereq = 1; r.eaddr = 32'h1008; push();
    r.rst = 1; r.ereq = 0; r.eb = 4'h0; push();
    // w2 redirected while waiting for data, then a stalled bundle killed by halt.
    r.sv = 1; r.sw = 2; r.spc = 32'h300; r.eb = 4'h4; push();
    r.ereq = 1; r.eaddr = 32'h300; push();
    r.ereq = 0; push();
    r.rv = 1; r.rw = 2; r.rpc = 32'h400; push();
    r.rsp = 1; r.ra = 32'h300; push();
    r.ereq = 1; r.eaddr = 32'h400; push();
    r.ereq = 0; push();
    r.rsp = 1; r.ra = 32'h400; r.eout = 1; r.ew = 2; r.epc = 32'h400; r.ei1v = 1; push();
    r.ordy = 0; r.sv = 1; r.sw = 0; r.spc = 32'h500; r.eb = 4'h5; push();
    push(); push(); push(); push();
    r.hv = 1; r.hw = 2; r.eout = 0; r.eb = 4'h1; push();
    r.ordy = 1; r.ereq = 1; r.eaddr = 32'h500; push();
    // Same-cycle halt and adv on w0, then a stray response while idle.
    r.ereq = 0; push();
    r.rsp = 1; r.ra = 32'h500; r.eout = 1; r.ew = 0; r.epc = 32'h500; r.ei1v = 1; push();
    r.eout = 0; push();
    r.hv = 1; r.hw = 0; r.av = 1; r.aw = 0; r.eb = 4'h0; push();
    push();
    r.rsp = 1; r.ra = 32'h0; push();

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      rst_n              = !v.rst;
      bus.start_valid    = v.sv;  bus.start_warp = v.sw; bus.start_pc = v.spc;
      bus.halt_valid     = v.hv;  bus.halt_warp  = v.hw;
      bus.redir_valid    = v.rv;  bus.redir_warp = v.rw; bus.redir_pc = v.rpc;
      bus.adv_valid      = v.av;  bus.adv_warp   = v.aw; bus.adv_bytes = v.ab;
      bus.imem_req_ready = v.rdy;
      bus.imem_rsp_valid = v.rsp;
      bus.imem_rsp_data  = {word(v.ra + 32'd4), word(v.ra)};
      bus.out_ready      = v.ordy;
      tick();
      chk("req_valid", i, 32'(bus.imem_req_valid), 32'(v.ereq));
      if (v.ereq) chk("req_addr", i, bus.imem_req_addr, v.eaddr);
      chk("out_valid", i, 32'(bus.out_valid), 32'(v.eout));
      chk("inst0_valid", i, 32'(bus.out_inst0_valid), 32'(v.eout));
      chk("inst1_valid", i, 32'(bus.out_inst1_valid), 32'(v.eout & v.ei1v));
      if (v.eout) begin
        chk("out_warp", i, 32'(bus.out_warp), 32'(v.ew));
        chk("out_pc", i, bus.out_pc, v.epc);
        chk("inst0", i, bus.out_inst0, word(v.epc));
        chk("inst1", i, bus.out_inst1, word({v.epc[31:3], 3'b000} + 32'd4));
      end
      chk("busy", i, 32'(bus.busy_warps), 32'(v.eb));
    end

    // PC wrap at the top of memory, adv clamp, and replay with an ignored start.
    idle_inputs();
    rst_n = 1;
    bus.start_valid = 1; bus.start_warp = 3; bus.start_pc = 32'hFFFF_FFFC;
    tick();
    bus.start_valid = 0;
    fetch_one(32'hFFFF_FFF8, 32'hFFFF_FFFC, 2'd3, 1'b0);
    bus.adv_valid = 1; bus.adv_warp = 3; bus.adv_bytes = 4'd8;
    tick();
    bus.adv_valid = 0;
    fetch_one(32'h0, 32'h0, 2'd3, 1'b1);
    bus.adv_valid = 1; bus.adv_warp = 3; bus.adv_bytes = 4'd0;
    bus.start_valid = 1; bus.start_warp = 3; bus.start_pc = 32'h700;
    tick();
    bus.adv_valid = 0; bus.start_valid = 0;
    fetch_one(32'h0, 32'h0, 2'd3, 1'b1);
    bus.halt_valid = 1; bus.halt_warp = 3;
    tick();
    bus.halt_valid = 0;
    chk("hs_busy_after_halt", 0, 32'(bus.busy_warps), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
